if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, the instruction memory and the IF/ID pipeline register.
//  Feeds the ID stage directly. Also provides a program-load write port, so benches load code through ports, not hierarchy.
//  Accepts stall from the hazard unit and PC redirects (branch/jump) from later stages.
// PARAMETERS
//  IMEM_DEPTH   128   instruction words in memory; word index = pc[31:2]
//  INSTR_COUNT  102   program length in words; fetch halts when pc == INSTR_COUNT*4
//  NOP_WORD     32'h0000_0020   bubble word (add $0,$0,$0)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   synchronous, active-high reset
//  prog_we        in   1   program-load write enable
//  prog_addr      in   7   program-load word address ($clog2(IMEM_DEPTH))
//  prog_data      in   32  program-load word
//  stall_i        in   1   ID not ready: hold PC and IF/ID register
//  redirect_i     in   1   taken branch/jump from downstream: flush and load PC
//  redirect_pc_i  in   32  redirect target byte address
//  fetch_pc_o     out  32  current PC (address being fetched)
//  fd_pc_o        out  32  PC of instruction in IF/ID register
//  fd_instr_o     out  32  instruction in IF/ID register
//  fd_valid_o     out  1   IF/ID holds a real instruction
//  fd_jtaken_o    out  1   instruction was a J already taken in fetch (see CONFIGURATION)
//  done_o         out  1   fetch reached INSTR_COUNT*4; sticky until rst or redirect
//  fetch_cnt_o    out  32  count of valid instructions issued to ID
// BEHAVIOUR
//  - Reset (rst=1 at posedge): pc=0, fd_pc=0, fd_instr=NOP_WORD, fd_valid=0, fd_jtaken=0, done=0, fetch_cnt=0.
//    Imem contents are NOT cleared. Reset mid-run discards in-flight state the same way.
//  - Imem: sync write (prog_we), async read. Word index >= IMEM_DEPTH reads NOP_WORD.
//    Write and fetch to the same word in one cycle: the fetch sees the OLD word.
//  - Latency: the word at pc appears on fd_* one cycle after the fetch cycle.
//  - Priority per cycle: rst > redirect_i > stall_i > done > normal fetch.
//  - redirect_i: pc <= {redirect_pc_i[31:2],2'b00}; fd_instr <= NOP_WORD, fd_valid <= 0, fd_jtaken <= 0; done <= 0.
//    Applies even while stall_i=1: the flush overrides the hold.
//  - stall_i (no redirect): pc, fd_*, fetch_cnt all hold.
//  - done (pc == INSTR_COUNT*4): pc holds; fd_instr <= NOP_WORD, fd_valid <= 0. done_o is registered: it goes high the cycle pc reaches the limit.
//  - Normal: fd_pc <= pc; fd_instr <= imem[pc>>2]; fd_valid <= 1; pc <= next_pc (pc+4 unless CONFIGURATION says otherwise).
//    fetch_cnt increments by 1 each cycle fd_valid is loaded with 1; 32-bit, wraps at 2^32-1 -> 0.
//  - pc+4 wraps mod 2^32. There is no fetch from addresses at or beyond the limit.
// CONFIGURATION
//  FETCH_JUMP_EN defined: fetch pre-decodes opcode[31:26]==6'b000010 (J).
//    next_pc = {pc_plus4[31:28], instr[25:0], 2'b00}; fd_jtaken <= 1 for that instruction. Downstream must not redirect on it.
//    The J costs zero bubbles. redirect_i still overrides the pre-decoded target in the same cycle.
//  FETCH_JUMP_EN undefined: no pre-decode; next_pc = pc+4 always; fd_jtaken_o tied 0.
// TESTING
//  1. Load words 0..5, release rst. fd_pc 0,4,8,... on successive cycles; fd_valid=1 from cycle 1; fetch_cnt_o=6 after 6 fetches.
//  2. stall_i=1 for 3 cycles at pc=0x10 -> fd_pc/fd_instr frozen at 0x0C; pc stays 0x10; fetch_cnt unchanged; resumes with fd_pc=0x10.
//  3. redirect_i=1 with redirect_pc_i=0x91 and stall_i=1 in the same cycle -> next cycle fd_valid=0, fd_instr=0x00000020;
//     fetch_pc_o=0x90, then fd_pc=0x90.
//  4. INSTR_COUNT=4, run free -> done_o=1 once pc=0x10; fd_valid=0 thereafter; redirect to 0 clears done and refetches word 0.
//  5. FETCH_JUMP_EN: word 12 = 0x08000012 -> cycle after fd_pc=0x30, fd_pc=0x48 with no bubble; fd_jtaken=1 on the J.
//     Without the macro: fd_pc=0x34 follows.
//  6. rst asserted mid-run at pc=0x40 -> next cycle all outputs at reset values, imem intact; refetch from 0 matches the loaded word 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS instruction-fetch stage.
// Holds the PC, a word-addressed instruction memory with a program-load
// write port, and the IF/ID pipeline register that feeds decode.
// Build option: define FETCH_JUMP_EN to let fetch take J instructions itself
// (zero-bubble jump); otherwise fetch always advances by pc+4.
module if_fetch_stage #(
    parameter int          IMEM_DEPTH  = 128,
    parameter int          INSTR_COUNT = 102,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0020
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    input  logic                          stall_i,
    input  logic                          redirect_i,
    input  logic [31:0]                   redirect_pc_i,
    output logic [31:0]                   fetch_pc_o,
    output logic [31:0]                   fd_pc_o,
    output logic [31:0]                   fd_instr_o,
    output logic                          fd_valid_o,
    output logic                          fd_jtaken_o,
    output logic                          done_o,
    output logic [31:0]                   fetch_cnt_o
);

    localparam int          ADDR_W = $clog2(IMEM_DEPTH);
    localparam logic [31:0] LIMIT  = 32'(INSTR_COUNT * 4);

    logic [31:0] r_imem [IMEM_DEPTH];

    logic [31:0] r_pc;
    logic [31:0] r_fd_pc;
    logic [31:0] r_fd_instr;
    logic        r_fd_valid;
    logic        r_fd_jtaken;
    logic        r_done;
    logic [31:0] r_fetch_cnt;

    logic [29:0]       w_word_idx;
    logic [ADDR_W-1:0] w_imem_idx;
    logic              w_in_range;
    logic [31:0]       w_fetch_instr;
    logic [31:0]       w_pc_plus4;
    logic [31:0]       w_next_pc;
    logic [31:0]       w_redirect_pc;
    logic              w_at_limit;
    logic              w_is_j;

    // Program-load port: synchronous write, memory is never cleared by reset.
    always_ff @(posedge clk) begin
        if (prog_we && (32'(prog_addr) < 32'(IMEM_DEPTH))) begin
            r_imem[prog_addr] <= prog_data;
        end
    end

    // Asynchronous read; a same-cycle write lands at the edge, so fetch sees the old word.
    always_comb begin
        w_word_idx    = r_pc[31:2];
        w_imem_idx    = r_pc[ADDR_W+1:2];
        w_in_range    = ({2'b00, w_word_idx} < 32'(IMEM_DEPTH));
        w_fetch_instr = w_in_range ? r_imem[w_imem_idx] : NOP_WORD;
    end

    // Next-PC selection, with optional pre-decode of J in fetch.
    always_comb begin
        w_pc_plus4    = r_pc + 32'd4;
        w_redirect_pc = redirect_pc_i & ~32'h0000_0003;
        w_at_limit    = (r_pc >= LIMIT);
`ifdef FETCH_JUMP_EN
        w_is_j        = (w_fetch_instr[31:26] == 6'b000010);
        w_next_pc     = w_is_j ? {w_pc_plus4[31:28], w_fetch_instr[25:0], 2'b00}
                               : w_pc_plus4;
`else
        w_is_j        = 1'b0;
        w_next_pc     = w_pc_plus4;
`endif
    end

    // PC, IF/ID register, done flag and issue counter; priority rst > redirect > stall > done > fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= 32'd0;
            r_fd_pc     <= 32'd0;
            r_fd_instr  <= NOP_WORD;
            r_fd_valid  <= 1'b0;
            r_fd_jtaken <= 1'b0;
            r_done      <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else if (redirect_i) begin
            r_pc        <= w_redirect_pc;
            r_fd_instr  <= NOP_WORD;
            r_fd_valid  <= 1'b0;
            r_fd_jtaken <= 1'b0;
            r_done      <= 1'b0;
        end else if (stall_i) begin
            r_pc        <= r_pc;
        end else if (w_at_limit) begin
            r_fd_instr  <= NOP_WORD;
            r_fd_valid  <= 1'b0;
            r_fd_jtaken <= 1'b0;
            r_done      <= 1'b1;
        end else begin
            r_fd_pc     <= r_pc;
            r_fd_instr  <= w_fetch_instr;
            r_fd_valid  <= 1'b1;
            r_fd_jtaken <= w_is_j;
            r_pc        <= w_next_pc;
            r_done      <= (w_next_pc >= LIMIT);
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign fetch_pc_o  = r_pc;
    assign fd_pc_o     = r_fd_pc;
    assign fd_instr_o  = r_fd_instr;
    assign fd_valid_o  = r_fd_valid;
    assign fd_jtaken_o = r_fd_jtaken;
    assign done_o      = r_done;
    assign fetch_cnt_o = r_fetch_cnt;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a default-sized instance driven from a
// vector table, and a short-program instance (INSTR_COUNT=4) for the halt case.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0020;
`ifdef FETCH_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        prog_we = 1'b0;
    logic [6:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;

    logic        rst = 1'b1, stall = 1'b0, redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic [31:0] fetch_pc, fd_pc, fd_instr, fetch_cnt;
    logic        fd_valid, fd_jtaken, done;

    logic        rst2 = 1'b1, stall2 = 1'b0, redir2 = 1'b0;
    logic [31:0] redir_pc2 = '0;
    logic [31:0] fetch_pc2, fd_pc2, fd_instr2, fetch_cnt2;
    logic        fd_valid2, fd_jtaken2, done2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .stall_i(stall), .redirect_i(redir), .redirect_pc_i(redir_pc),
        .fetch_pc_o(fetch_pc), .fd_pc_o(fd_pc), .fd_instr_o(fd_instr), .fd_valid_o(fd_valid),
        .fd_jtaken_o(fd_jtaken), .done_o(done), .fetch_cnt_o(fetch_cnt)
    );

    if_fetch_stage #(.INSTR_COUNT(4)) dut_short (
        .clk(clk), .rst(rst2), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .stall_i(stall2), .redirect_i(redir2), .redirect_pc_i(redir_pc2),
        .fetch_pc_o(fetch_pc2), .fd_pc_o(fd_pc2), .fd_instr_o(fd_instr2), .fd_valid_o(fd_valid2),
        .fd_jtaken_o(fd_jtaken2), .done_o(done2), .fetch_cnt_o(fetch_cnt2)
    );

    typedef struct {
        string       name;
        logic        rst, stall, redir, we;
        logic [31:0] redir_pc;
        logic [6:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] e_pc, e_fd_pc, e_instr, e_cnt;
        logic        e_valid, e_jt, e_done, chk_fd_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] word(input int i);
        if (i == 12) return 32'h0800_0012;
        return 32'hA000_0000 | 32'(i);
    endfunction

    function automatic vec_t mk(input string name, input logic r, input logic s, input logic rd,
                                input logic [31:0] rpc, input logic [31:0] epc,
                                input logic chk, input logic [31:0] efd, input logic [31:0] ein,
                                input logic ev, input logic ejt, input logic [31:0] ecnt);
        vec_t v;
        v.name = name; v.rst = r; v.stall = s; v.redir = rd; v.redir_pc = rpc;
        v.we = 1'b0; v.waddr = '0; v.wdata = '0;
        v.e_pc = epc; v.chk_fd_pc = chk; v.e_fd_pc = efd; v.e_instr = ein;
        v.e_valid = ev; v.e_jt = ejt; v.e_done = 1'b0; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_short(input string n, input logic [31:0] epc, input logic [31:0] efd,
                               input logic [31:0] ein, input logic ev, input logic ed,
                               input logic [31:0] ecnt);
        check({n, ".pc"},    fetch_pc2, epc);
        check({n, ".fd_pc"}, fd_pc2, efd);
        check({n, ".instr"}, fd_instr2, ein);
        check({n, ".valid"}, 32'(fd_valid2), 32'(ev));
        check({n, ".done"},  32'(done2), 32'(ed));
        check({n, ".cnt"},   fetch_cnt2, ecnt);
    endtask

    initial begin
        vec_t v;
        // Program load while both instances are held in reset.
        for (int i = 0; i < 128; i++) begin
            prog_we = 1'b1; prog_addr = 7'(i); prog_data = word(i);
            tick();
        end
        prog_we = 1'b0;

        check("rst.pc",     fetch_pc, 32'd0);
        check("rst.fd_pc",  fd_pc, 32'd0);
        check("rst.instr",  fd_instr, NOP);
        check("rst.valid",  32'(fd_valid), 32'd0);
        check("rst.jt",     32'(fd_jtaken), 32'd0);
        check("rst.done",   32'(done), 32'd0);
        check("rst.cnt",    fetch_cnt, 32'd0);

        // Short program: halt at pc=0x10, then redirect clears done and refetches word 0.
        rst2 = 1'b0;
        tick(); check_short("short1", 32'h04, 32'h00, word(0), 1'b1, 1'b0, 32'd1);
        tick(); check_short("short2", 32'h08, 32'h04, word(1), 1'b1, 1'b0, 32'd2);
        tick(); check_short("short3", 32'h0C, 32'h08, word(2), 1'b1, 1'b0, 32'd3);
        tick(); check_short("short4", 32'h10, 32'h0C, word(3), 1'b1, 1'b1, 32'd4);
        tick(); check_short("short5", 32'h10, 32'h0C, NOP,     1'b0, 1'b1, 32'd4);
        tick(); check_short("short6", 32'h10, 32'h0C, NOP,     1'b0, 1'b1, 32'd4);
        redir2 = 1'b1; redir_pc2 = 32'h0;
        tick(); check_short("short_redir", 32'h00, 32'h0C, NOP, 1'b0, 1'b0, 32'd4);
        redir2 = 1'b0;
        tick(); check_short("short_refetch", 32'h04, 32'h00, word(0), 1'b1, 1'b0, 32'd5);
        rst2 = 1'b1;

        // Main vector table.
        vecs.push_back(mk("seq0",  0,0,0,0, 32'h04, 1, 32'h00, word(0), 1, 0, 1));
        vecs.push_back(mk("seq1",  0,0,0,0, 32'h08, 1, 32'h04, word(1), 1, 0, 2));
        vecs.push_back(mk("seq2",  0,0,0,0, 32'h0C, 1, 32'h08, word(2), 1, 0, 3));
        vecs.push_back(mk("seq3",  0,0,0,0, 32'h10, 1, 32'h0C, word(3), 1, 0, 4));
        vecs.push_back(mk("stl1",  0,1,0,0, 32'h10, 1, 32'h0C, word(3), 1, 0, 4));
        vecs.push_back(mk("stl2",  0,1,0,0, 32'h10, 1, 32'h0C, word(3), 1, 0, 4));
        vecs.push_back(mk("stl3",  0,1,0,0, 32'h10, 1, 32'h0C, word(3), 1, 0, 4));
        vecs.push_back(mk("resume",0,0,0,0, 32'h14, 1, 32'h10, word(4), 1, 0, 5));
        vecs.push_back(mk("seq5",  0,0,0,0, 32'h18, 1, 32'h14, word(5), 1, 0, 6));
        vecs.push_back(mk("redir_stall", 0,1,1,32'h91, 32'h90, 0, 32'h0, NOP, 0, 0, 6));
        vecs.push_back(mk("post_redir",  0,0,0,0, 32'h94, 1, 32'h90, word(36), 1, 0, 7));
        vecs.push_back(mk("to_j",  0,0,1,32'h30, 32'h30, 0, 32'h0, NOP, 0, 0, 7));
        vecs.push_back(mk("j_fetch", 0,0,0,0, JEN ? 32'h48 : 32'h34, 1, 32'h30, word(12), 1, JEN, 8));
        vecs.push_back(mk("after_j", 0,0,0,0, JEN ? 32'h4C : 32'h38, 1, JEN ? 32'h48 : 32'h34,
                          word(JEN ? 18 : 13), 1, 0, 9));
        vecs.push_back(mk("to_40", 0,0,1,32'h40, 32'h40, 0, 32'h0, NOP, 0, 0, 9));
        vecs.push_back(mk("mid_rst", 1,1,1,32'h80, 32'h00, 1, 32'h00, NOP, 0, 0, 0));
        vecs.push_back(mk("refetch0", 0,0,0,0, 32'h04, 1, 32'h00, word(0), 1, 0, 1));
        v = mk("wr_same", 0,0,0,0, 32'h08, 1, 32'h04, word(1), 1, 0, 2);
        v.we = 1'b1; v.waddr = 7'd1; v.wdata = 32'h1234_5678;
        vecs.push_back(v);
        vecs.push_back(mk("back_to_4", 0,0,1,32'h04, 32'h04, 0, 32'h0, NOP, 0, 0, 2));
        vecs.push_back(mk("new_word", 0,0,0,0, 32'h08, 1, 32'h04, 32'h1234_5678, 1, 0, 3));

        foreach (vecs[k]) begin
            rst = vecs[k].rst; stall = vecs[k].stall; redir = vecs[k].redir;
            redir_pc = vecs[k].redir_pc;
            prog_we = vecs[k].we; prog_addr = vecs[k].waddr; prog_data = vecs[k].wdata;
            tick();
            prog_we = 1'b0;
            check({vecs[k].name, ".pc"},    fetch_pc, vecs[k].e_pc);
            if (vecs[k].chk_fd_pc) check({vecs[k].name, ".fd_pc"}, fd_pc, vecs[k].e_fd_pc);
            check({vecs[k].name, ".instr"}, fd_instr, vecs[k].e_instr);
            check({vecs[k].name, ".valid"}, 32'(fd_valid), 32'(vecs[k].e_valid));
            check({vecs[k].name, ".jt"},    32'(fd_jtaken), 32'(vecs[k].e_jt));
            check({vecs[k].name, ".done"},  32'(done), 32'(vecs[k].e_done));
            check({vecs[k].name, ".cnt"},   fetch_cnt, vecs[k].e_cnt);
        end
        rst = 1'b0; stall = 1'b0; redir = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
